// File: rtl/sram_req_if.sv
// Requester-side handshake bundle for one sram_arbiter port: request, direction,
// address/write data in, read data and a one-cycle done pulse back.
interface sram_req_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;

    modport master (output req, we, addr, wdata, input rdata, done);
    modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin sharer of one asynchronous SRAM port between CPU (port A) and debug/loader (port B).
// Optional SRAM_ARB_STATS_EN adds per-port 16-bit grant counters a_grants/b_grants.
module sram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    sram_req_if.slave         a,
    sram_req_if.slave         b,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              OE,
    output logic              WE,
    output logic              busy
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]       a_grants,
    output logic [15:0]       b_grants
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    port_t      winner;
    port_t      last_grant;
    logic       we_q;
    logic [3:0] cnt;
    logic       grant_a;
    logic       grant_b;

    // NOTE: the grant decision is pure continuous assignment, so no path can
    // leave a combinational signal unassigned and infer a latch.
    assign grant_a = a.req && (!b.req || last_grant == PORT_B);
    assign grant_b = b.req && !grant_a;

    // NOTE: all state and registered outputs use non-blocking assignment so every
    // right-hand side sees the pre-edge value, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            winner       <= PORT_A;
            last_grant   <= PORT_B;
            we_q         <= 1'b0;
            cnt          <= '0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            OE           <= 1'b1;
            WE           <= 1'b1;
            busy         <= 1'b0;
            a.rdata      <= '0;
            b.rdata      <= '0;
            a.done       <= 1'b0;
            b.done       <= 1'b0;
`ifdef SRAM_ARB_STATS_EN
            a_grants     <= '0;
            b_grants     <= '0;
`endif
        end else begin
            a.done <= 1'b0;
            b.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state        <= SETUP;
                        busy         <= 1'b1;
                        winner       <= grant_a ? PORT_A : PORT_B;
                        last_grant   <= grant_a ? PORT_A : PORT_B;
                        we_q         <= grant_a ? a.we    : b.we;
                        ADDR         <= grant_a ? a.addr  : b.addr;
                        Data_to_SRAM <= grant_a ? a.wdata : b.wdata;
`ifdef SRAM_ARB_STATS_EN
                        if (grant_a) a_grants <= a_grants + 16'd1;
                        else         b_grants <= b_grants + 16'd1;
`endif
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= CNT_INIT;
                    OE    <= we_q;
                    WE    <= !we_q;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        OE    <= 1'b1;
                        WE    <= 1'b1;
                        // Read data is sampled on the same edge that releases OE.
                        if (winner == PORT_A) begin
                            a.done <= 1'b1;
                            if (!we_q) a.rdata <= Data_from_SRAM;
                        end else begin
                            b.done <= 1'b1;
                            if (!we_q) b.rdata <= Data_from_SRAM;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT_CYCLES=2) with a behavioural SRAM model.
// Define SRAM_ARB_STATS_EN to also check the grant counters.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        OE;
    logic        WE;
    logic        busy;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] a_grants;
    logic [15:0] b_grants;
    int          exp_a_grants = 0;
    int          exp_b_grants = 0;
`endif

    int          errors = 0;
    int          checks = 0;

    int          wr_count = 0;
    logic [15:0] wr_last_addr = '0;
    logic [15:0] wr_last_data = '0;

    sram_req_if a_if ();
    sram_req_if b_if ();

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .a              (a_if),
        .b              (b_if),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .OE             (OE),
        .WE             (WE),
        .busy           (busy)
`ifdef SRAM_ARB_STATS_EN
        ,
        .a_grants       (a_grants),
        .b_grants       (b_grants)
`endif
    );

    always #5 Clk = ~Clk;

    // SRAM contents: 0x0010 holds 0xBEEF, every other address reads addr ^ 0x5A00.
    function automatic logic [15:0] sram_word(input logic [15:0] addr);
        return (addr == 16'h0010) ? 16'hBEEF : (addr ^ 16'h5A00);
    endfunction

    assign Data_from_SRAM = OE ? 16'hxxxx : sram_word(ADDR);

    always @(posedge Clk) begin
        if (Reset_n && !WE) begin
            wr_count     <= wr_count + 1;
            wr_last_addr <= ADDR;
            wr_last_data <= Data_to_SRAM;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_idle(input string name, input int cyc);
        checks++;
        if (busy !== 1'b0 || a_if.done !== 1'b0 || b_if.done !== 1'b0 || OE !== 1'b1 || WE !== 1'b1) begin
            errors++;
            $display("FAIL %s cycle %0d idle: busy=%b a_done=%b b_done=%b OE=%b WE=%b, want busy=0 dones=0 OE=1 WE=1",
                     name, cyc, busy, a_if.done, b_if.done, OE, WE);
        end
    endtask

    // Called at the negedge of cycle 0 (the IDLE cycle that sees the request);
    // walks cycles 1..4 and returns at the negedge of the DONE cycle.
    task automatic watch_access(input string name, input bit is_b, input bit wr,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input bit pulse_req);
        logic exp_oe, exp_we;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (pulse_req && k == 1) begin
                if (is_b) b_if.req = 1'b0;
                else      a_if.req = 1'b0;
            end
            exp_oe = !(!wr && (k == 2 || k == 3));
            exp_we = !( wr && (k == 2 || k == 3));
            checks++;
            if (OE !== exp_oe) begin
                errors++;
                $display("FAIL %s cycle %0d OE: got %b want %b", name, k, OE, exp_oe);
            end
            checks++;
            if (WE !== exp_we) begin
                errors++;
                $display("FAIL %s cycle %0d WE: got %b want %b", name, k, WE, exp_we);
            end
            checks++;
            if (ADDR !== addr || Data_to_SRAM !== wdata) begin
                errors++;
                $display("FAIL %s cycle %0d bus: ADDR=%h data=%h want ADDR=%h data=%h",
                         name, k, ADDR, Data_to_SRAM, addr, wdata);
            end
            checks++;
            if (a_if.done !== (!is_b && k == 4) || b_if.done !== (is_b && k == 4)) begin
                errors++;
                $display("FAIL %s cycle %0d done: a_done=%b b_done=%b want %b %b",
                         name, k, a_if.done, b_if.done, (!is_b && k == 4), (is_b && k == 4));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s cycle %0d busy: got %b want 1", name, k, busy);
            end
        end
`ifdef SRAM_ARB_STATS_EN
        if (is_b) exp_b_grants++;
        else      exp_a_grants++;
`endif
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (OE !== 1'b1 || WE !== 1'b1 || ADDR !== 16'h0 || Data_to_SRAM !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: OE=%b WE=%b ADDR=%h data=%h busy=%b want 1 1 0000 0000 0",
                     OE, WE, ADDR, Data_to_SRAM, busy);
        end
        checks++;
        if (a_if.done !== 1'b0 || b_if.done !== 1'b0 || a_if.rdata !== 16'h0 || b_if.rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset ports: a_done=%b b_done=%b a_rdata=%h b_rdata=%h want 0 0 0000 0000",
                     a_if.done, b_if.done, a_if.rdata, b_if.rdata);
        end
        Reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check_idle("reset_idle", c);
        end
    endtask

    task automatic test_a_read();
        a_if.we = 1'b0; a_if.addr = 16'h0010; a_if.wdata = 16'h0C0C; a_if.req = 1'b1;
        watch_access("a_read", 1'b0, 1'b0, 16'h0010, 16'h0C0C, 1'b0);
        a_if.req = 1'b0;
        a_if.addr = 16'hFFFF;
        checks++;
        if (a_if.rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL a_read rdata: got %h want BEEF", a_if.rdata);
        end
        step();
        check_idle("a_read_after", 5);
        step();
        check_idle("a_read_after", 6);
    endtask

    task automatic test_b_write();
        int wc0;
        wc0 = wr_count;
        b_if.we = 1'b1; b_if.addr = 16'h0003; b_if.wdata = 16'h1234; b_if.req = 1'b1;
        watch_access("b_write", 1'b1, 1'b1, 16'h0003, 16'h1234, 1'b0);
        b_if.req = 1'b0;
        checks++;
        if (wr_count - wc0 != 2 || wr_last_addr !== 16'h0003 || wr_last_data !== 16'h1234) begin
            errors++;
            $display("FAIL b_write sram: write cycles=%0d addr=%h data=%h want 2 0003 1234",
                     wr_count - wc0, wr_last_addr, wr_last_data);
        end
        step();
        check_idle("b_write_after", 5);
    endtask

    task automatic test_round_robin();
        a_if.we = 1'b0; a_if.addr = 16'h0020; a_if.wdata = 16'h0000;
        b_if.we = 1'b0; b_if.addr = 16'h0021; b_if.wdata = 16'h1111;
        a_if.req = 1'b1; b_if.req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 0) watch_access("rr_a", 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0);
            else            watch_access("rr_b", 1'b1, 1'b0, 16'h0021, 16'h1111, 1'b0);
            if (n == 3) begin
                a_if.req = 1'b0; b_if.req = 1'b0;
            end
            checks++;
            if (a_if.rdata !== 16'h5A20 || (n > 0 && b_if.rdata !== 16'h5A21)) begin
                errors++;
                $display("FAIL rr rdata after access %0d: a=%h b=%h want a=5A20 b=5A21",
                         n, a_if.rdata, b_if.rdata);
            end
            step();
            check_idle("rr_gap", n);
        end
`ifdef SRAM_ARB_STATS_EN
        checks++;
        if (a_grants !== 16'(exp_a_grants) || b_grants !== 16'(exp_b_grants)) begin
            errors++;
            $display("FAIL rr grants: a=%0d b=%0d want a=%0d b=%0d", a_grants, b_grants, exp_a_grants, exp_b_grants);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        int wc0;
        wc0 = wr_count;
        a_if.we = 1'b1; a_if.addr = 16'h0030; a_if.wdata = 16'h5555; a_if.req = 1'b1;
        step();
        step();
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset pre: WE got %b want 0 in ACCESS", WE);
        end
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (WE !== 1'b1 || OE !== 1'b1 || busy !== 1'b0 || ADDR !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset async: WE=%b OE=%b busy=%b ADDR=%h want 1 1 0 0000", WE, OE, busy, ADDR);
        end
        a_if.req = 1'b0;
`ifdef SRAM_ARB_STATS_EN
        exp_a_grants = 0;
        exp_b_grants = 0;
`endif
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("mid_reset_after", c);
        end
        checks++;
        if (wr_count != wc0) begin
            errors++;
            $display("FAIL mid_reset writes: got %0d write cycles want 0", wr_count - wc0);
        end
        a_if.we = 1'b0; a_if.addr = 16'h0040; a_if.wdata = 16'h0101; a_if.req = 1'b1;
        watch_access("post_reset_read", 1'b0, 1'b0, 16'h0040, 16'h0101, 1'b0);
        a_if.req = 1'b0;
        checks++;
        if (a_if.rdata !== 16'h5A40) begin
            errors++;
            $display("FAIL post_reset_read rdata: got %h want 5A40", a_if.rdata);
        end
        step();
        check_idle("post_reset_after", 5);
    endtask

    task automatic test_req_pulse();
        a_if.we = 1'b0; a_if.addr = 16'h0050; a_if.wdata = 16'h0202; a_if.req = 1'b1;
        watch_access("req_pulse", 1'b0, 1'b0, 16'h0050, 16'h0202, 1'b1);
        checks++;
        if (a_if.rdata !== 16'h5A50) begin
            errors++;
            $display("FAIL req_pulse rdata: got %h want 5A50", a_if.rdata);
        end
        for (int c = 5; c <= 8; c++) begin
            step();
            check_idle("req_pulse_after", c);
        end
`ifdef SRAM_ARB_STATS_EN
        checks++;
        if (a_grants !== 16'(exp_a_grants) || b_grants !== 16'(exp_b_grants)) begin
            errors++;
            $display("FAIL final grants: a=%0d b=%0d want a=%0d b=%0d", a_grants, b_grants, exp_a_grants, exp_b_grants);
        end
`endif
    endtask

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        test_reset();
        test_a_read();
        test_b_write();
        test_round_robin();
        test_reset_mid_access();
        test_req_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
